pulse_stretcher: RTL
====================

PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter PULSE_LEN, default 4, number of cycles o_level is held high per accepted trigger; legal range 1..2^CNT_W.
REQ-002 Parameter GAP_LEN, default 2, number of low hold-off cycles after each pulse; legal range 0..2^CNT_W.
REQ-003 Parameter CNT_W, default 8, width of the internal cycle counter.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_sclr_n  input  1  reset; synchronous, active-low.
REQ-006 i_trig  input  1  single-cycle trigger strobe, e.g. an edge-detector rise output; sampled every rising edge.
REQ-007 o_level  output  1  stretched pulse, registered.
REQ-008 o_busy  output  1  high in HIGH and GAP states, registered.
REQ-009 o_done  output  1  one-cycle strobe on return to IDLE, registered.
REQ-010 o_drop_cnt  output  8  saturating count of ignored triggers, registered.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, HIGH, GAP.
REQ-012 IDLE with i_trig=1 at edge t0 SHALL enter HIGH and load the counter with PULSE_LEN-1.
REQ-013 o_level SHALL go high on edge t0 and stay high for exactly PULSE_LEN cycles, i.e. it is low again on edge t0+PULSE_LEN.
REQ-014 In HIGH, the counter SHALL decrement each cycle; at zero the FSM SHALL leave HIGH: to GAP with counter = GAP_LEN-1 if GAP_LEN>0, otherwise to IDLE.
REQ-015 In GAP, o_level SHALL be 0, o_busy 1, and the counter SHALL decrement; at zero the FSM SHALL enter IDLE.
REQ-016 o_done SHALL be 1 for exactly the first cycle after entering IDLE from HIGH or GAP, and 0 otherwise.
REQ-017 o_busy SHALL be 1 exactly when the state is HIGH or GAP.
REQ-018 Any i_trig=1 in GAP SHALL be ignored and SHALL increment o_drop_cnt.
REQ-019 On the edge leaving GAP (or leaving HIGH with GAP_LEN=0), i_trig=1 SHALL be dropped; a trigger is accepted only when sampled in IDLE.
REQ-020 o_drop_cnt SHALL saturate at 255 and never wrap.
REQ-021 i_trig in HIGH SHALL be handled per REQ-027/REQ-028.
REQ-022 The counter SHALL be CNT_W bits wide, and the loads PULSE_LEN-1 and GAP_LEN-1 SHALL be truncated to CNT_W bits.

Reset
REQ-023 On a rising edge with i_sclr_n=0, the block SHALL enter IDLE, clear the counter, and drive o_level=0, o_busy=0, o_done=0, o_drop_cnt=0.
REQ-024 Reset SHALL override i_trig and any in-progress pulse on that same edge; no o_done is produced for an aborted pulse.
REQ-025 With i_sclr_n=0, no asynchronous path SHALL affect any output.
REQ-026 The first trigger SHALL be accepted on the first edge where i_sclr_n=1.

Configuration
REQ-027 With macro PULSE_STRETCHER_RETRIGGER_EN defined, i_trig=1 in HIGH SHALL reload the counter with PULSE_LEN-1, so o_level stays high PULSE_LEN cycles after the last trigger; o_drop_cnt is unchanged.
REQ-028 Without PULSE_STRETCHER_RETRIGGER_EN, i_trig=1 in HIGH SHALL be ignored and SHALL increment o_drop_cnt; pulse length is fixed at PULSE_LEN.

Verification
REQ-029 Reset: i_sclr_n=0 for 2 cycles while i_trig=1 -> all outputs 0 throughout, and on release o_drop_cnt=0.
REQ-030 Basic pulse (PULSE_LEN=4, GAP_LEN=2): one i_trig at edge 0 -> o_level high edges 0..3, low at 4; o_busy high 0..5; o_done=1 at edge 6 only.
REQ-031 Hold-off: trigger at 0, triggers at 4 and 5 -> both ignored, o_drop_cnt=2, and a new trigger at 7 is accepted.
REQ-032 Retrigger, macro defined: triggers at 0 and 2 -> o_level high 0..5, o_drop_cnt=0. Macro undefined: o_level high 0..3, o_drop_cnt=1.
REQ-033 GAP_LEN=0: triggers at 0 and 4 -> trigger at 4 dropped, o_done=1 at 4, and a trigger at 5 is accepted.
REQ-034 Saturation and mid-reset: 300 dropped triggers -> o_drop_cnt=255; then i_sclr_n=0 at edge 2 of a pulse -> o_level=0 next sample, and no o_done.

Source files
------------

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - trigger-to-fixed-width pulse stretcher with hold-off gap and drop counter
// Optional feature macro: PULSE_STRETCHER_RETRIGGER_EN (retrigger in HIGH reloads the pulse counter)

module pulse_stretcher #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       i_sclr_n,
  input  logic       i_trig,
  output logic       o_level,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Counter loads are deliberately truncated to the counter width.
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       drop_q, drop_d;
  logic             drop_inc;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drop_inc = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_trig) begin
          state_d = S_HIGH;
          cnt_d   = PULSE_LOAD;
        end
      end

      S_HIGH: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        if (i_trig) begin
          cnt_d = PULSE_LOAD;
        end else if (cnt_q == '0) begin
          if (GAP_LEN > 0) begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`else
        drop_inc = i_trig;
        if (cnt_q == '0) begin
          if (GAP_LEN > 0) begin
            state_d = S_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end

      S_GAP: begin
        // Triggers during hold-off, including the exit edge, are never accepted.
        drop_inc = i_trig;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    level_d = (state_d == S_HIGH);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_IDLE) && (state_q != S_IDLE);
    drop_d  = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
  end

  // State, counter and output registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign o_level    = level_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_drop_cnt = drop_q;

endmodule
